mux_2x1: RTL and testbench

// - Parameterised 2-to-1 word multiplexer for datapath operand/result selection.
// - Provides a combinational output `out` and a registered copy `out_q`.
// - Both outputs are in the single `clk` domain.
// - Used wherever the datapath picks between two same-width buses (ALU source, writeback source, PC next).

---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_2x1_core.sv | 29 ++
 rtl/mux_2x1.sv | 65 ++++++
 tb/tb_mux_2x1.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 2-to-1 word multiplexer.
//   MUX_DEFAULT_WIDTH : default data width used by mux_2x1 and mux_2x1_core
//   SEL_IN0 / SEL_IN1 : select encodings for in0 / in1
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 32;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_2x1_core.sv
// Combinational 2-to-1 word selector.
// Ports:
//   in0 [WIDTH] : data returned when sel selects in0
//   in1 [WIDTH] : data returned when sel selects in1
//   sel         : 0 -> in0, 1 -> in1; any unknown value falls back to in0
//   out [WIDTH] : selected word, zero latency
module mux_2x1_core
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // A case with a default arm (rather than ?:) sends an X/Z select to in0
  // instead of merging both inputs into X.
  always_comb begin
    out = in0;
    case (sel)
      SEL_IN1: out = in1;
      SEL_IN0: out = in0;
      default: out = in0;
    endcase
  end

endmodule : mux_2x1_core

// File: rtl/mux_2x1.sv
// Parameterised 2-to-1 word multiplexer with a combinational result and a
// registered copy of it. Optional parity bit on the registered copy, enabled
// by defining MUX_2X1_PARITY_EN.
// Ports:
//   clk           : rising-edge clock
//   rst           : synchronous active-high reset, has priority over en
//   in0, in1      : WIDTH-bit data inputs
//   sel           : select, 0 -> in0, 1 -> in1
//   en            : load enable for out_q / sel_q (/ out_par)
//   out   [WIDTH] : combinational mux result, never reset
//   out_q [WIDTH] : out registered on enabled edges, resets to 0
//   sel_q         : sel registered alongside out_q, resets to 0
//   out_par       : (MUX_2X1_PARITY_EN only) XOR-reduction of out_q, resets to 0
module mux_2x1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
`ifdef MUX_2X1_PARITY_EN
  ,
  output logic             out_par
`endif
);

  mux_2x1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .in0 (in0),
    .in1 (in1),
    .sel (sel),
    .out (out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      sel_q <= SEL_IN0;
    end else if (en) begin
      out_q <= out;
      sel_q <= sel;
    end
  end

`ifdef MUX_2X1_PARITY_EN
  // Parity is taken from the word being loaded so it lines up with out_q
  // on the same edge instead of lagging it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (en) begin
      out_par <= ^out;
    end
  end
`endif

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1 (WIDTH = 32). Directed vector table, a
// toggle sequence and a randomized run against a behavioural model.
module tb_mux_2x1;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         sel;
  logic         en;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         sel_q;
`ifdef MUX_2X1_PARITY_EN
  logic         out_par;
`endif

  int total;
  int bad;

  mux_2x1 #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in0   (in0),
    .in1   (in1),
    .sel   (sel),
    .en    (en),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
`ifdef MUX_2X1_PARITY_EN
    ,
    .out_par (out_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic         sel;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_q;
    logic         exp_sel_q;
    logic         exp_par;
  } vec_t;

  vec_t vecs[9];

  // Model of the registered outputs, updated once per applied edge.
  logic [W-1:0] m_q;
  logic         m_sel_q;
  logic         m_par;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int popcount(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    return s ? b : a;
  endfunction

  // Drive away from the active edge, check out, clock, then check registers.
  task automatic apply(input logic r, input logic e, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst = r;
    en  = e;
    sel = s;
    in0 = a;
    in1 = b;
    #1;
    check("out", out, pick(s, a, b));
    if (r) begin
      m_q     = '0;
      m_sel_q = 1'b0;
      m_par   = 1'b0;
    end else if (e) begin
      m_q     = pick(s, a, b);
      m_sel_q = s;
      m_par   = (popcount(m_q) % 2) == 1;
    end
    @(posedge clk);
    #1;
    check("out_q", out_q, m_q);
    check("sel_q", {{(W-1){1'b0}}, sel_q}, {{(W-1){1'b0}}, m_sel_q});
`ifdef MUX_2X1_PARITY_EN
    check("out_par", {{(W-1){1'b0}}, out_par}, {{(W-1){1'b0}}, m_par});
`endif
  endtask

  initial begin
    logic [W-1:0] prev_out;
    total   = 0;
    bad     = 0;
    m_q     = '0;
    m_sel_q = 1'b0;
    m_par   = 1'b0;
    rst = 1'b1; en = 1'b0; sel = 1'b0; in0 = '0; in1 = '0;

    //           rst   en    sel   in0           in1           out           q             selq  par
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 32'h0,       1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0,       1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h5555_5555, 32'h0,       1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h5555_5555, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1};

    // Directed table with hand-computed expectations.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      en  = vecs[i].en;
      sel = vecs[i].sel;
      in0 = vecs[i].in0;
      in1 = vecs[i].in1;
      #1;
      check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_q", i), out_q, vecs[i].exp_q);
      check($sformatf("vec%0d sel_q", i), {{(W-1){1'b0}}, sel_q},
            {{(W-1){1'b0}}, vecs[i].exp_sel_q});
`ifdef MUX_2X1_PARITY_EN
      check($sformatf("vec%0d out_par", i), {{(W-1){1'b0}}, out_par},
            {{(W-1){1'b0}}, vecs[i].exp_par});
`endif
      // Out must stay on the selected input after the edge, whatever rst did.
      check($sformatf("vec%0d out_post", i), out, vecs[i].exp_out);
    end
    m_q     = vecs[8].exp_q;
    m_sel_q = vecs[8].exp_sel_q;
    m_par   = vecs[8].exp_par;

    // Toggle sequence: out_q must equal the previous cycle's out.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      sel = i[0];
      in0 = 32'hAAAA_AAAA;
      in1 = 32'h5555_5555;
      #1;
      prev_out = out;
      @(posedge clk);
      #1;
      check("toggle out_q", out_q, prev_out);
      check("toggle sel_q", {{(W-1){1'b0}}, sel_q}, {{(W-1){1'b0}}, i[0]});
    end
    m_q     = 32'h5555_5555;
    m_sel_q = 1'b1;
    m_par   = 1'b0;

    // Randomized run against the behavioural model.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_2x1
